// File: rtl/brick_mover.sv
// Active-piece controller: turns button pulses and gravity into fit-check candidates,
// commits accepted ones, locks landed bricks, spawns the next type and detects game over.
module brick_mover #(
    parameter int X_W        = 4,
    parameter int Y_W        = 5,
    parameter int TYPE_W     = 3,
    parameter int NUM_TYPES  = 7,
    parameter int SPAWN_X    = 6,
    parameter int SPAWN_Y    = 0,
    parameter int GRAV_TICKS = 8
) (
    input  logic              clk_div22,
    input  logic              rst_1plus,
    input  logic              enable,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic              btn_rot_ccw,
    input  logic              btn_rot_cw,
    input  logic              btn_drop,
    output logic              chk_req,
    output logic [TYPE_W-1:0] chk_type,
    output logic [1:0]        chk_dir,
    output logic [X_W-1:0]    chk_x,
    output logic [Y_W-1:0]    chk_y,
    input  logic              chk_valid,
    input  logic              chk_ok,
    output logic [TYPE_W-1:0] brick_type,
    output logic [1:0]        dir,
    output logic [X_W-1:0]    cur_x,
    output logic [Y_W-1:0]    cur_y,
    output logic              lock,
    output logic              game_over
);
    localparam int GW = $clog2(GRAV_TICKS);
    localparam logic [X_W-1:0]    X_MAX  = '1;
    localparam logic [Y_W-1:0]    Y_MAX  = '1;
    localparam logic [GW-1:0]     G_LAST = GW'(GRAV_TICKS - 1);
    localparam logic [TYPE_W-1:0] T_LAST = TYPE_W'(NUM_TYPES);

    typedef enum logic [2:0] {S_SPAWN, S_IDLE, S_CHECK, S_LOCK, S_OVER} state_t;
    typedef enum logic [1:0] {K_SPAWN, K_MOVE, K_ROT, K_DOWN} kind_t;

    state_t            state;
    kind_t             kind;
    logic [TYPE_W-1:0] next_type;
    logic [GW-1:0]     grav_cnt;
    logic              drop_mode;

    // IDLE action decode in priority order; only one action is taken per cycle
    logic           down, issue, any_btn;
    kind_t          c_kind;
    logic [1:0]     c_dir;
    logic [X_W-1:0] c_x;
    logic [Y_W-1:0] c_y;

    assign any_btn = btn_drop | btn_rot_ccw | btn_rot_cw | btn_left | btn_right;

    always_comb begin
        down   = 1'b0;
        issue  = 1'b0;
        c_kind = K_MOVE;
        c_dir  = dir;
        c_x    = cur_x;
        c_y    = cur_y;
        if (btn_drop || grav_cnt == G_LAST) begin
            down   = 1'b1;
            c_kind = K_DOWN;
            c_y    = cur_y + Y_W'(1);
        end else if (btn_rot_ccw) begin
            issue  = 1'b1;
            c_kind = K_ROT;
            c_dir  = dir + 2'd1;
        end else if (btn_rot_cw) begin
            issue  = 1'b1;
            c_kind = K_ROT;
            c_dir  = dir - 2'd1;
        end else if (btn_left) begin
            issue  = (cur_x != '0);
            c_x    = cur_x - X_W'(1);
        end else if (btn_right) begin
            issue  = (cur_x != X_MAX);
            c_x    = cur_x + X_W'(1);
        end
    end

    always_ff @(posedge clk_div22 or posedge rst_1plus) begin
        if (rst_1plus) begin
            state      <= S_SPAWN;
            kind       <= K_SPAWN;
            brick_type <= '0;
            dir        <= '0;
            cur_x      <= X_W'(SPAWN_X);
            cur_y      <= Y_W'(SPAWN_Y);
            next_type  <= TYPE_W'(1);
            grav_cnt   <= '0;
            drop_mode  <= 1'b0;
            chk_req    <= 1'b0;
            chk_type   <= '0;
            chk_dir    <= '0;
            chk_x      <= '0;
            chk_y      <= '0;
            lock       <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            lock <= 1'b0;
            case (state)
                S_SPAWN: begin
                    chk_req  <= 1'b1;
                    chk_type <= next_type;
                    chk_dir  <= '0;
                    chk_x    <= X_W'(SPAWN_X);
                    chk_y    <= Y_W'(SPAWN_Y);
                    kind     <= K_SPAWN;
                    state    <= S_CHECK;
                end
                S_IDLE: if (enable) begin
                    if (down) begin
                        if (btn_drop) drop_mode <= 1'b1;
                        else          grav_cnt  <= '0;
                    end else if (!any_btn) begin
                        grav_cnt <= grav_cnt + GW'(1);
                    end
                    // bottom row: nothing below can fit, land without asking
                    if (down && cur_y == Y_MAX) begin
                        lock  <= 1'b1;
                        state <= S_LOCK;
                    end else if (down || issue) begin
                        chk_req  <= 1'b1;
                        chk_type <= brick_type;
                        chk_dir  <= c_dir;
                        chk_x    <= c_x;
                        chk_y    <= c_y;
                        kind     <= c_kind;
                        state    <= S_CHECK;
                    end
                end
                S_CHECK: if (chk_valid) begin
                    if (chk_ok) begin
                        dir   <= chk_dir;
                        cur_x <= chk_x;
                        cur_y <= chk_y;
                        if (kind == K_SPAWN) begin
                            brick_type <= chk_type;
                            next_type  <= (next_type == T_LAST) ? TYPE_W'(1) : next_type + TYPE_W'(1);
                        end
                        // hard drop keeps requesting one row lower until something stops it
                        if (kind == K_DOWN && drop_mode) begin
                            if (chk_y == Y_MAX) begin
                                chk_req <= 1'b0;
                                lock    <= 1'b1;
                                state   <= S_LOCK;
                            end else begin
                                chk_y <= chk_y + Y_W'(1);
                            end
                        end else begin
                            chk_req <= 1'b0;
                            state   <= S_IDLE;
                        end
                    end else begin
                        chk_req <= 1'b0;
                        case (kind)
                            K_DOWN: begin
                                lock  <= 1'b1;
                                state <= S_LOCK;
                            end
                            K_SPAWN: begin
                                game_over <= 1'b1;
                                state     <= S_OVER;
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
                S_LOCK: begin
                    drop_mode <= 1'b0;
                    grav_cnt  <= '0;
                    state     <= S_SPAWN;
                end
                S_OVER:  state <= S_OVER;
                default: state <= S_SPAWN;
            endcase
        end
    end
endmodule

// File: doc/brick_mover.md
# brick_mover

Parametrised active-piece controller for the playing field. It owns the falling brick's type, direction and position, and turns one-pulse button events and a gravity tick into move, rotate and drop candidates. Each candidate goes to an external fit checker through a req/valid handshake. The block commits accepted candidates, locks the brick when a downward move fails, spawns the next type, and flags game over when a spawn fails. It sits between the debounce/one-pulse button stage and the board/display logic.

## Interface
- X_W, 4, width of x coordinate
- Y_W, 5, width of y coordinate (y grows downward)
- TYPE_W, 3, brick type width; 0 = no brick
- NUM_TYPES, 7, types cycle 1..NUM_TYPES
- SPAWN_X, 6, spawn column
- SPAWN_Y, 0, spawn row
- GRAV_TICKS, 8, IDLE cycles per gravity step (≥2)

Ports:
- clk_div22  in  1  clock
- rst_1plus  in  1  reset, asynchronous, active-high
- enable  in  1  gravity and button processing allowed
- btn_left, btn_right, btn_rot_ccw, btn_rot_cw, btn_drop  in  1 each  one-cycle pulses
- chk_req  out  1  candidate valid, held until accepted
- chk_type  out  TYPE_W  candidate type
- chk_dir  out  2  candidate direction
- chk_x  out  X_W  candidate x
- chk_y  out  Y_W  candidate y
- chk_valid  in  1  checker verdict valid (same cycle as chk_req allowed)
- chk_ok  in  1  candidate fits (meaningful only with chk_valid)
- brick_type  out  TYPE_W  committed type
- dir  out  2  committed direction
- cur_x  out  X_W  committed x
- cur_y  out  Y_W  committed y
- lock  out  1  one-cycle pulse: brick landed
- game_over  out  1  sticky

## Operation
- States: SPAWN, IDLE, CHECK, LOCK, OVER. Each candidate has a kind: SPAWN, MOVE, ROT or DOWN. A drop_mode flag is kept separately.
- Reset values: state SPAWN, brick_type 0, dir 0, cur_x SPAWN_X, cur_y SPAWN_Y, next_type 1, grav_cnt 0, drop_mode 0, chk_req 0, all chk_* 0, lock 0, game_over 0.
- SPAWN:
  - Candidate (next_type, 0, SPAWN_X, SPAWN_Y), kind SPAWN.
  - Next state CHECK.
- IDLE with enable=1: one action per cycle, in priority order:
  - btn_drop: set drop_mode, DOWN candidate.
  - Gravity: grav_cnt reaches GRAV_TICKS-1; grav_cnt resets to 0; DOWN candidate.
  - btn_rot_ccw: dir+1 mod 4.
  - btn_rot_cw: dir-1 mod 4.
  - btn_left: x-1.
  - btn_right: x+1.
  - Lower-priority pulses in the same cycle are dropped.
  - Otherwise grav_cnt increments.
- IDLE with enable=0: everything frozen; pulses dropped.
- Local rejects (no request issued, stay IDLE):
  - left at cur_x=0.
  - right at cur_x=2^X_W-1.
- DOWN at cur_y=2^Y_W-1 needs no request; it goes directly to LOCK.
- CHECK: chk_req=1 and chk_* stable until a cycle with chk_valid=1. Pulses arriving in CHECK are dropped. On chk_valid:
  - ok, kind SPAWN: commit; brick_type←next_type; next_type advances (NUM_TYPES wraps to 1); next state IDLE.
  - ok, kind MOVE/ROT: commit; next state IDLE.
  - ok, kind DOWN, drop_mode=0: commit; next state IDLE.
  - ok, kind DOWN, drop_mode=1: commit; new DOWN candidate y+1; remain CHECK; chk_req stays 1. At y max, go to LOCK instead.
  - not ok, kind MOVE/ROT: discard; next state IDLE.
  - not ok, kind DOWN: next state LOCK.
  - not ok, kind SPAWN: next state OVER.
- LOCK: lock=1 for exactly one cycle; drop_mode cleared; grav_cnt cleared; next state SPAWN.
- OVER: game_over=1 and chk_req=0; all inputs ignored until reset.
- Arithmetic: dir is 2-bit natural wrap. x/y never wrap, because of the local rejects.

## Timing
- All outputs registered.
- chk_* and chk_req are updated on entry to CHECK.
- Zero-latency checker (chk_valid tied to chk_req), button pulse sampled at edge N:
  - CHECK during cycle N+1.
  - Committed outputs change at edge N+2.
- Checker latency of L cycles adds L to the above.
- After a lock:
  - lock high one cycle.
  - SPAWN next cycle.
  - CHECK the cycle after.
- Hard drop of k rows with a zero-latency checker takes k+1 CHECK cycles, then LOCK.
- Reset asserted mid-CHECK: chk_req drops asynchronously and all state returns to reset values. A verdict arriving later is ignored.

## Test plan
- Reset, chk_valid=chk_req, chk_ok=1 -> first spawn commits brick_type=1, cur=(6,0), dir=0. Gravity then increments cur_y every 8 IDLE cycles.
- btn_left pulses with cur_x=0 -> chk_req never asserts, cur_x stays 0. btn_rot_cw at dir=0 -> dir=3 two cycles later.
- btn_left and btn_rot_ccw in the same cycle -> only dir+1 is applied; x unchanged.
- Checker rejects y≥10, btn_drop at y=2 -> cur_y steps to 9, one lock pulse, then the spawn candidate has type 2. After type 7, type 1 is spawned.
- Checker holds chk_valid low 5 cycles -> chk_req and chk_* stay stable for 5 cycles; a btn_right during the wait is dropped.
- Spawn candidate rejected -> game_over=1 sticky, chk_req=0. Pulses are ignored until rst_1plus, which restores all reset values.
